// File: rtl/uart_framed.sv
// uart_framed: full-duplex UART with framed TX and RX paths.
//   Frame: start(0), DATA_W data bits LSB first, optional even parity,
//   STOP_BITS stop(1); every bit lasts CLKS_PER_BIT clk cycles.
//   Optional feature macro: UART_FRAMED_PARITY_EN (even parity on TX, checked on RX).
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   tx_data/valid     word offered for transmission; tx_ready high only when TX idle
//   serial_tx         registered serial output, idle high
//   serial_rx         asynchronous serial input, idle high
//   rx_data/valid     received word, rx_valid is a one-cycle pulse
//   rx_frame_err      stop bit sampled low (qualified by rx_valid)
//   rx_parity_err     parity mismatch (qualified by rx_valid), 0 without parity
//
// Both FSMs share one encoding:
//   state    | meaning
//   S_IDLE   | line idle, waiting for a word (TX) or a start edge (RX)
//   S_START  | start bit (TX driving 0 / RX waiting for the mid-point)
//   S_DATA   | data bits, LSB first
//   S_PARITY | even-parity bit (only with parity enabled)
//   S_STOP   | stop bit(s)
module uart_framed #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_tx,
  input  logic              serial_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_parity_err
);

  localparam int TX_CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int RX_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_W);

  localparam logic [TX_CNT_W-1:0] TX_BIT_LOAD  = TX_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TX_CNT_W-1:0] TX_STOP_LOAD = TX_CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [RX_CNT_W-1:0] RX_BIT_LOAD  = RX_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [RX_CNT_W-1:0] RX_HALF_LOAD = RX_CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0]    IDX_LAST     = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- TX
  state_t                tx_state, tx_state_nxt;
  logic [TX_CNT_W-1:0]   tx_cnt;
  logic [IDX_W-1:0]      tx_idx;
  logic [DATA_W-1:0]     tx_shift;
  logic                  tx_tc, tx_accept, tx_line_nxt, serial_tx_q;
`ifdef UART_FRAMED_PARITY_EN
  logic                  tx_par;
`endif

  assign tx_tc     = (tx_cnt == '0);
  assign tx_ready  = (tx_state == S_IDLE) && !rst;
  assign tx_accept = tx_valid && tx_ready;
  assign serial_tx = serial_tx_q;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_accept) tx_state_nxt = S_START;
      S_START:  if (tx_tc) tx_state_nxt = S_DATA;
      S_DATA:   if (tx_tc && tx_idx == IDX_LAST) begin
`ifdef UART_FRAMED_PARITY_EN
                  tx_state_nxt = S_PARITY;
`else
                  tx_state_nxt = S_STOP;
`endif
                end
      S_PARITY: if (tx_tc) tx_state_nxt = S_STOP;
      S_STOP:   if (tx_tc) tx_state_nxt = S_IDLE;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

  // Level the line takes in the next cycle; registered so serial_tx is a flop.
  // On a bit boundary inside DATA the shifter has not advanced yet, so look one bit ahead.
  always_comb begin
    tx_line_nxt = 1'b1;
    case (tx_state_nxt)
      S_START:  tx_line_nxt = 1'b0;
      S_DATA:   tx_line_nxt = (tx_state == S_DATA && tx_tc) ? tx_shift[1] : tx_shift[0];
`ifdef UART_FRAMED_PARITY_EN
      S_PARITY: tx_line_nxt = tx_par;
`endif
      default:  tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      serial_tx_q <= 1'b1;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
`ifdef UART_FRAMED_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      serial_tx_q <= tx_line_nxt;
      if (tx_accept) begin
        tx_shift <= tx_data;
        tx_idx   <= '0;
        tx_cnt   <= TX_BIT_LOAD;
`ifdef UART_FRAMED_PARITY_EN
        tx_par   <= ^tx_data;
`endif
      end else if (tx_state != S_IDLE) begin
        if (tx_tc) begin
          if (tx_state_nxt == S_STOP)      tx_cnt <= TX_STOP_LOAD;
          else if (tx_state_nxt == S_IDLE) tx_cnt <= '0;
          else                             tx_cnt <= TX_BIT_LOAD;
          if (tx_state == S_DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_idx   <= tx_idx + IDX_W'(1);
          end
        end else begin
          tx_cnt <= tx_cnt - TX_CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX
  state_t                rx_state, rx_state_nxt;
  logic                  rx_s1, rx_s2, rx_prev;
  logic [RX_CNT_W-1:0]   rx_cnt;
  logic [IDX_W-1:0]      rx_idx;
  logic [DATA_W-1:0]     rx_shift, rx_data_q;
  logic                  rx_tc, rx_fall, rx_done, rx_shift_en;
  logic                  rx_valid_q, rx_frame_err_q;
`ifdef UART_FRAMED_PARITY_EN
  logic                  rx_par_bad, rx_parity_err_q;
`endif

  assign rx_tc   = (rx_cnt == '0);
  // Edge detect on the synchronized line: a line held low after a bad stop bit
  // never looks like a new start until it has gone high again.
  assign rx_fall = rx_prev && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_fall) rx_state_nxt = S_START;
      S_START:  if (rx_tc) rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tc && rx_idx == IDX_LAST) begin
`ifdef UART_FRAMED_PARITY_EN
                  rx_state_nxt = S_PARITY;
`else
                  rx_state_nxt = S_STOP;
`endif
                end
      S_PARITY: if (rx_tc) rx_state_nxt = S_STOP;
      S_STOP:   if (rx_tc) rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done     = 1'b0;
    rx_shift_en = 1'b0;
    case (rx_state)
      S_DATA:  rx_shift_en = rx_tc;
      S_STOP:  rx_done     = rx_tc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1          <= 1'b1;
      rx_s2          <= 1'b1;
      rx_prev        <= 1'b1;
      rx_cnt         <= '0;
      rx_idx         <= '0;
      rx_shift       <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef UART_FRAMED_PARITY_EN
      rx_par_bad      <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_s1      <= serial_rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_valid_q <= rx_done;
      if (rx_state == S_IDLE) begin
        if (rx_fall) begin
          rx_cnt <= RX_HALF_LOAD;
          rx_idx <= '0;
        end
      end else if (rx_tc) begin
        rx_cnt <= (rx_state_nxt == S_IDLE) ? '0 : RX_BIT_LOAD;
      end else begin
        rx_cnt <= rx_cnt - RX_CNT_W'(1);
      end
      if (rx_shift_en) begin
        rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
        rx_idx   <= rx_idx + IDX_W'(1);
      end
`ifdef UART_FRAMED_PARITY_EN
      if (rx_state == S_PARITY && rx_tc) rx_par_bad <= rx_s2 ^ (^rx_shift);
      if (rx_done) rx_parity_err_q <= rx_par_bad;
`endif
      if (rx_done) begin
        rx_data_q      <= rx_shift;
        rx_frame_err_q <= ~rx_s2;
      end
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
`ifdef UART_FRAMED_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_framed.sv
module tb_uart_framed;

  localparam int DW = 8;
  localparam int C  = 16;
  localparam int SB = 1;
`ifdef UART_FRAMED_PARITY_EN
  localparam int P = 1;
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam int EXP_BUSY = 176;
`else
  localparam int P = 0;
  localparam logic [9:0] EXP_A5 = 10'b1101001010;
  localparam int EXP_BUSY = 160;
`endif
  localparam int NB = 1 + DW + P + SB;
  // start edge on the line -> rx_valid: 2 sync flops + edge flop, half bit, then one bit per sample
  localparam int RX_LAT = 4 + C / 2 + (DW + P + 1) * C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, serial_tx, serial_rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_frame_err, rx_parity_err;
  logic          rx_drive = 1'b1;
  logic          loopback = 1'b0;

  assign serial_rx = loopback ? serial_tx : rx_drive;

  uart_framed #(.DATA_W(DW), .CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .serial_tx(serial_tx), .serial_rx(serial_rx),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model
  typedef struct { int cyc; logic [DW-1:0] data; logic ferr; logic perr; } rx_ev_t;
  logic    tx_q[$];      // expected serial_tx level for each upcoming cycle of a frame
  rx_ev_t  rx_q[$];      // expected rx_valid events
  logic [DW-1:0] m_rx_data = '0;
  logic    m_ferr = 1'b0, m_perr = 1'b0;
  bit      m_live = 1'b0;
  int      rx_pulses = 0;
  logic [DW-1:0] seen_data[$];
  logic    seen_ferr[$];
  logic    seen_perr[$];

  function automatic logic frame_bit(input logic [DW-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (P != 0 && b == DW + 1) return ^d;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_rx_data = '0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      else if (tx_valid) begin
        for (int k = 0; k < NB * C; k++) tx_q.push_back(frame_bit(tx_data, k / C));
        if (loopback) rx_q.push_back('{cyc + RX_LAT, tx_data, 1'b0, 1'b0});
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("tx_ready", tx_ready, (tx_q.size() == 0) && !rst);
      check("serial_tx", serial_tx, (tx_q.size() != 0) ? tx_q[0] : 1'b1);
      if (rx_q.size() != 0 && rx_q[0].cyc < cyc) begin
        check("rx_valid_missing", 32'(rx_valid), 32'd1);
        void'(rx_q.pop_front());
      end
      if (rx_valid) begin
        rx_ev_t e;
        rx_pulses++;
        seen_data.push_back(rx_data);
        seen_ferr.push_back(rx_frame_err);
        seen_perr.push_back(rx_parity_err);
        if (rx_q.size() == 0) begin
          check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          e = rx_q.pop_front();
          check("rx_valid_cycle", cyc, e.cyc);
          m_rx_data = e.data;
          m_ferr = e.ferr;
          m_perr = e.perr;
        end
      end
      check("rx_data", rx_data, m_rx_data);
      check("rx_frame_err", rx_frame_err, m_ferr);
      check("rx_parity_err", rx_parity_err, m_perr);
    end
  end

  // ---------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [DW-1:0] d, input logic par, input logic stop);
    rx_ev_t e;
    e.cyc  = cyc + RX_LAT;
    e.data = d;
    e.ferr = ~stop;
    e.perr = (P != 0) ? (par != ^d) : 1'b0;
    rx_q.push_back(e);
    rx_drive = 1'b0;
    tick(C);
    for (int i = 0; i < DW; i++) begin
      rx_drive = d[i];
      tick(C);
    end
    if (P != 0) begin
      rx_drive = par;
      tick(C);
    end
    rx_drive = stop;
    tick(C);
    rx_drive = 1'b1;
    tick(2 * C);
  endtask

  initial begin
    logic [NB-1:0] bits;
    int busy;
    int p0;

    // reset values
    tick(3);
    check("rst_serial_tx", serial_tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", tx_ready, 1'b1);
    tick(1);

    // 8'hA5 on the wire; tx_data changed after handshake must not matter
    bits = '0;
    busy = 0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data = 8'hFF;
    for (int k = 0; k < NB * C + 20; k++) begin
      @(negedge clk);
      if (!tx_ready) busy++;
      if (k % C == C / 2 && k / C < NB) bits[k / C] = serial_tx;
    end
    check("a5_waveform", 32'(bits), 32'(EXP_A5));
    check("a5_busy_cycles", busy, EXP_BUSY);
    tick(1);

    // loopback, back-to-back 3C then C3
    loopback = 1'b1;
    seen_data.delete(); seen_ferr.delete(); seen_perr.delete();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 8'hC3;
    tick(NB * C + 1);
    tx_valid = 1'b0;
    tick(NB * C + 40);
    check("loop_count", seen_data.size(), 2);
    if (seen_data.size() >= 2) begin
      check("loop_word0", seen_data[0], 8'h3C);
      check("loop_word1", seen_data[1], 8'hC3);
      check("loop_errs", {seen_ferr[0], seen_perr[0], seen_ferr[1], seen_perr[1]}, 4'b0000);
    end
    loopback = 1'b0;
    tick(4);

    // 4-cycle glitch is a false start; RX must then take a good frame
    p0 = rx_pulses;
    rx_drive = 1'b0;
    tick(4);
    rx_drive = 1'b1;
    tick(40);
    check("glitch_no_pulse", rx_pulses - p0, 0);
    send_rx(8'h5A, ^8'h5A, 1'b1);
    check("after_glitch_data", rx_data, 8'h5A);
    check("after_glitch_pulses", rx_pulses - p0, 1);

    // stop bit low -> frame error, data still delivered
    send_rx(8'h96, ^8'h96, 1'b0);
    check("ferr_data", rx_data, 8'h96);
    check("ferr_flag", rx_frame_err, 1'b1);
    send_rx(8'h11, ^8'h11, 1'b1);
    check("ferr_cleared", rx_frame_err, 1'b0);

`ifdef UART_FRAMED_PARITY_EN
    send_rx(8'h01, 1'b0, 1'b1);
    check("parity_bad", rx_parity_err, 1'b1);
    send_rx(8'h01, 1'b1, 1'b1);
    check("parity_good", rx_parity_err, 1'b0);
`endif

    // reset during data bit 3 of a loopback frame
    loopback = 1'b1;
    p0 = rx_pulses;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(4 * C + 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_serial_tx", serial_tx, 1'b1);
    check("abort_tx_ready", tx_ready, 1'b1);
    tick(300);
    check("abort_no_pulse", rx_pulses - p0, 0);
    check("rx_pending", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_framed.md
UART_FRAMED -- requirements
Module: uart_framed

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535, even values only.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tx_data  input  DATA_W  word to transmit, sampled on the TX handshake.
REQ-007 tx_valid  input  1  TX word offered.
REQ-008 tx_ready  output  1  TX idle, able to accept a word.
REQ-009 serial_tx  output  1  serial line out, idle high.
REQ-010 serial_rx  input  1  asynchronous serial line in, idle high.
REQ-011 rx_data  output  DATA_W  last received word.
REQ-012 rx_valid  output  1  one-cycle pulse, new rx_data available.
REQ-013 rx_frame_err  output  1  qualified by rx_valid; stop bit sampled low.
REQ-014 rx_parity_err  output  1  qualified by rx_valid; parity mismatch.

Function
REQ-015 Frame shall be: start(0), DATA_W data bits LSB first, optional parity (REQ-033), STOP_BITS stop(1); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 TX FSM shall have states IDLE, START, DATA, PARITY, STOP; tx_ready is high only in IDLE.
REQ-017 TX handshake: tx_valid && tx_ready on a rising edge latches tx_data and enters START; serial_tx goes low in the following cycle.
REQ-018 TX shall ignore tx_valid outside IDLE; tx_data changes after the handshake shall not affect the frame in flight.
REQ-019 After the last stop-bit cycle TX returns to IDLE with tx_ready high; back-to-back words shall leave zero idle bit-times between frames.
REQ-020 serial_tx shall be driven from a flop (glitch-free).
REQ-021 RX shall pass serial_rx through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-022 RX FSM shall have states IDLE, START, DATA, PARITY, STOP.
REQ-023 In IDLE, a synchronized high-to-low transition enters START and loads the bit counter with CLKS_PER_BIT/2.
REQ-024 At the START mid-point, a sampled 1 is a false start: return to IDLE with no rx_valid pulse.
REQ-025 Each data, parity and stop bit is sampled once, CLKS_PER_BIT cycles after the previous sample; data bits are shifted LSB first.
REQ-026 RX samples only the first stop bit; the second stop bit (STOP_BITS=2) is not checked by RX.
REQ-027 After the stop-bit sample, in the same cycle: rx_data is updated, rx_valid pulses for 1 cycle, and rx_frame_err = ~stop_sample.
REQ-028 rx_data, rx_frame_err and rx_parity_err shall hold their values until the next rx_valid.
REQ-029 RX returns to IDLE right after the stop sample and then accepts a new start edge; a line stuck low after a frame error shall not start a new frame until the line returns high.
REQ-030 TX and RX shall be fully independent; a loopback of serial_tx to serial_rx shall be legal.

Reset
REQ-031 While rst=1 on a clock edge, both FSMs shall enter IDLE and all counters shall clear to 0.
REQ-032 Reset output values: serial_tx=1, tx_ready=0 during reset and 1 in the first cycle after reset, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0; synchronizer flops reset to 1; any frame in flight mid-operation is abandoned without an rx_valid pulse.

Configuration
REQ-033 Macro UART_FRAMED_PARITY_EN defined: one even-parity bit (XOR of the data bits) follows the data on TX; RX checks it, and rx_parity_err=1 on mismatch.
REQ-034 Macro UART_FRAMED_PARITY_EN undefined: PARITY states are skipped, frames carry no parity bit, and rx_parity_err is tied to 0.

Verification
REQ-035 Defaults, send tx_data=8'hA5 -> serial_tx = 0,1,0,1,0,0,1,0,1 then 1, each level held 16 cycles; tx_ready low for 160 cycles.
REQ-036 Loopback, send 8'h3C then 8'hC3 back-to-back -> two rx_valid pulses with rx_data 8'h3C then 8'hC3, both errors 0.
REQ-037 Drive serial_rx low for 4 cycles only -> no rx_valid pulse, and RX is back in IDLE.
REQ-038 Drive a frame with stop bit = 0 -> rx_valid=1 with rx_frame_err=1 and rx_data equal to the data bits sent.
REQ-039 UART_FRAMED_PARITY_EN defined, send 8'h01 with parity bit 0 -> rx_parity_err=1; with parity bit 1 -> rx_parity_err=0.
REQ-040 Assert rst during TX data bit 3 -> serial_tx=1 and tx_ready=1 in the cycle after rst drops, and no rx_valid pulse in loopback.
